// File: rtl/ir_assembler_if.sv
// Handshake/bus bundle between the MDR, the instruction assembler and the decode stage.
// Carries replay/prev_ir only when IR_ASSEMBLER_SHADOW_EN is defined.
interface ir_assembler_if #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned NUM_BYTES = 2,
    parameter int unsigned OPC_W     = 4
);
    localparam int unsigned IrW  = NUM_BYTES * DATA_W;
    localparam int unsigned IdxW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    logic              start;
    logic              load;
    logic [DATA_W-1:0] mdr_data;
    logic              consume;
    logic [IrW-1:0]    ir_out;
    logic [OPC_W-1:0]  opcode;
    logic [IrW-OPC_W-1:0] operand;
    logic              ir_valid;
    logic              busy;
    logic [IdxW-1:0]   byte_idx;
`ifdef IR_ASSEMBLER_SHADOW_EN
    logic              replay;
    logic [IrW-1:0]    prev_ir;
`endif

    modport master (
        output start, load, mdr_data, consume,
`ifdef IR_ASSEMBLER_SHADOW_EN
        output replay,
        input  prev_ir,
`endif
        input  ir_out, opcode, operand, ir_valid, busy, byte_idx
    );

    modport slave (
        input  start, load, mdr_data, consume,
`ifdef IR_ASSEMBLER_SHADOW_EN
        input  replay,
        output prev_ir,
`endif
        output ir_out, opcode, operand, ir_valid, busy, byte_idx
    );
endinterface

// File: rtl/ir_assembler.sv
// Assembles NUM_BYTES big-endian MDR fetches into one instruction word, published atomically
// with a valid/consume handshake. Optional trap-replay shadow: define IR_ASSEMBLER_SHADOW_EN.
module ir_assembler #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned NUM_BYTES = 2,
    parameter int unsigned OPC_W     = 4
) (
    input logic             clk,
    input logic             reset,
    ir_assembler_if.slave   bus
);
    localparam int unsigned   IrW     = NUM_BYTES * DATA_W;
    localparam int unsigned   IdxW    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_BYTES - 1);

    typedef enum logic [1:0] {StIdle, StFill, StFull} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [IrW-1:0]  asm_buf_q, asm_buf_d;
    logic [IrW-1:0]  ir_q, ir_d;
    logic [IrW-1:0]  last_word;
`ifdef IR_ASSEMBLER_SHADOW_EN
    logic [IrW-1:0]  prev_q, prev_d;
`endif

    // Final fetch always fills the least-significant byte.
    always_comb begin
        last_word                = asm_buf_q;
        last_word[DATA_W-1:0]    = bus.mdr_data;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        asm_buf_d = asm_buf_q;
        ir_d      = ir_q;
`ifdef IR_ASSEMBLER_SHADOW_EN
        prev_d    = prev_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d   = StFill;
                    idx_d     = '0;
                    asm_buf_d = '0;
                end
`ifdef IR_ASSEMBLER_SHADOW_EN
                else if (bus.replay) begin
                    ir_d    = prev_q;
                    state_d = StFull;
                end
`endif
            end
            StFill: begin
                if (bus.start) begin
                    // Restart discards partial bytes and this cycle's fetch.
                    idx_d     = '0;
                    asm_buf_d = '0;
                end else if (bus.load) begin
                    if (idx_q == LastIdx) begin
                        ir_d      = last_word;
`ifdef IR_ASSEMBLER_SHADOW_EN
                        prev_d    = ir_q;
`endif
                        idx_d     = '0;
                        asm_buf_d = '0;
                        state_d   = StFull;
                    end else begin
                        for (int unsigned k = 0; k < NUM_BYTES; k++) begin
                            if (idx_q == IdxW'(k)) begin
                                asm_buf_d[(NUM_BYTES-1-k)*DATA_W +: DATA_W] = bus.mdr_data;
                            end
                        end
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StFull: begin
                if (bus.consume) begin
                    state_d   = bus.start ? StFill : StIdle;
                    idx_d     = '0;
                    asm_buf_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            asm_buf_q <= '0;
            ir_q      <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            asm_buf_q <= asm_buf_d;
            ir_q      <= ir_d;
        end
    end

`ifdef IR_ASSEMBLER_SHADOW_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign bus.prev_ir = prev_q;
`endif

    assign bus.ir_out   = ir_q;
    assign bus.opcode   = ir_q[IrW-1 -: OPC_W];
    assign bus.operand  = ir_q[IrW-OPC_W-1:0];
    assign bus.ir_valid = (state_q == StFull);
    assign bus.busy     = (state_q == StFill);
    assign bus.byte_idx = (state_q == StFill) ? idx_q : '0;

endmodule
